// File: rtl/cache_write_buffer.sv
// Coalescing line write buffer: byte stores merge into line entries, which
// drain to the line-granular memory port strictly in allocation order.
module cache_write_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]               wr_addr_i,
  input  logic [WORD_WIDTH-1:0]               wr_data_i,
  input  logic [WORD_WIDTH/8-1:0]             wr_be_i,
  input  logic                                flush_i,
  input  logic [ADDR_WIDTH-1:0]               rd_addr_i,
  output logic                                rd_hit_o,
  output logic                                mem_valid_o,
  input  logic                                mem_ready_i,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic [LINE_WORDS*WORD_WIDTH-1:0]    mem_data_o,
  output logic [LINE_WORDS*WORD_WIDTH/8-1:0]  mem_be_o,
  output logic                                empty_o
);
  localparam int BPW    = WORD_WIDTH / 8;
  localparam int LBYTES = BPW * LINE_WORDS;
  localparam int LINE_W = LINE_WORDS * WORD_WIDTH;
  localparam int WOFF   = $clog2(BPW);
  localparam int OFF    = $clog2(LBYTES);
  localparam int TAG_W  = ADDR_WIDTH - OFF;
  localparam int AGE_W  = $clog2(TIMEOUT);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Closing on the edge where the age would reach TIMEOUT-1 makes an
  // untouched entry PEND exactly TIMEOUT-1 edges after its last write.
  localparam logic [AGE_W-1:0] AGE_CLOSE = AGE_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {ST_FREE, ST_OPEN, ST_PEND} ent_st_e;

  ent_st_e           st_q   [DEPTH];
  ent_st_e           st_d   [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];
  logic [LBYTES-1:0] mask_q [DEPTH];
  logic [LBYTES-1:0] mask_d [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [AGE_W-1:0]  age_d  [DEPTH];
  logic [PTR_W-1:0]  fifo_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [TAG_W-1:0]  wr_tag, rd_tag;
  int                widx;
  logic [DEPTH-1:0]  hit_open, is_free, rd_match;
  logic              any_hit, any_free, accept, do_alloc, hs;
  logic [PTR_W-1:0]  alloc_idx, head_idx;
  logic              unused_rd_off;

  function automatic logic [LINE_W-1:0] merge_data(input logic [LINE_W-1:0] line,
      input int w, input logic [WORD_WIDTH-1:0] wdata, input logic [BPW-1:0] be);
    logic [LINE_W-1:0] r;
    r = line;
    for (int j = 0; j < LBYTES; j++)
      if ((j / BPW) == w && be[j % BPW]) r[j*8 +: 8] = wdata[(j % BPW)*8 +: 8];
    return r;
  endfunction

  function automatic logic [LBYTES-1:0] merge_mask(input logic [LBYTES-1:0] m,
      input int w, input logic [BPW-1:0] be);
    logic [LBYTES-1:0] r;
    r = m;
    for (int j = 0; j < LBYTES; j++)
      if ((j / BPW) == w && be[j % BPW]) r[j] = 1'b1;
    return r;
  endfunction

  assign wr_tag        = wr_addr_i[ADDR_WIDTH-1:OFF];
  assign rd_tag        = rd_addr_i[ADDR_WIDTH-1:OFF];
  assign unused_rd_off = ^rd_addr_i[OFF-1:0];
  assign widx          = int'((32'(wr_addr_i) >> WOFF) % 32'(LINE_WORDS));

  always_comb begin
    hit_open = '0;
    is_free  = '0;
    rd_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_open[i] = (st_q[i] == ST_OPEN) && (tag_q[i] == wr_tag);
      is_free[i]  = (st_q[i] == ST_FREE);
      rd_match[i] = (st_q[i] != ST_FREE) && (tag_q[i] == rd_tag);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (is_free[i]) alloc_idx = PTR_W'(i);
  end

  assign any_hit     = |hit_open;
  assign any_free    = |is_free;
  assign wr_ready_o  = !flush_i && (any_hit || any_free);
  assign accept      = wr_valid_i && wr_ready_o;
  assign do_alloc    = accept && !any_hit;
  assign head_idx    = fifo_q[head_q];
  assign mem_valid_o = (cnt_q != '0) && (st_q[head_idx] == ST_PEND);
  assign hs          = mem_valid_o && mem_ready_i;
  assign mem_addr_o  = mem_valid_o ? {tag_q[head_idx], {OFF{1'b0}}} : '0;
  assign mem_data_o  = mem_valid_o ? data_q[head_idx] : '0;
  assign mem_be_o    = mem_valid_o ? mask_q[head_idx] : '0;
  assign rd_hit_o    = |rd_match;
  assign empty_o     = &is_free;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]   = st_q[i];
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
      mask_d[i] = mask_q[i];
      age_d[i]  = age_q[i];
      case (st_q[i])
        ST_FREE: begin
          if (do_alloc && alloc_idx == PTR_W'(i)) begin
            tag_d[i]  = wr_tag;
            data_d[i] = merge_data('0, widx, wr_data_i, wr_be_i);
            mask_d[i] = merge_mask('0, widx, wr_be_i);
            age_d[i]  = '0;
            st_d[i]   = (&mask_d[i]) ? ST_PEND : ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (accept && hit_open[i]) begin
            data_d[i] = merge_data(data_q[i], widx, wr_data_i, wr_be_i);
            mask_d[i] = merge_mask(mask_q[i], widx, wr_be_i);
            age_d[i]  = '0;
            if (&mask_d[i]) st_d[i] = ST_PEND;
          end else if (flush_i || age_q[i] == AGE_CLOSE) begin
            st_d[i] = ST_PEND;
          end else begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
        ST_PEND: begin
          if (hs && head_idx == PTR_W'(i)) st_d[i] = ST_FREE;
        end
        default: st_d[i] = ST_FREE;
      endcase
    end
  end

  // The allocation FIFO never overflows: a push needs a FREE entry.
  assign tail_d = do_alloc ? tail_q + PTR_W'(1) : tail_q;
  assign head_d = hs ? head_q + PTR_W'(1) : head_q;
  assign cnt_d  = cnt_q + CNT_W'(do_alloc) - CNT_W'(hs);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= ST_FREE;
        age_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= st_d[i];
        age_q[i] <= age_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
      mask_q[i] <= mask_d[i];
    end
    if (do_alloc) fifo_q[tail_q] <= alloc_idx;
  end
endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-of-lines reference model.
module tb_cache_write_buffer;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid, wr_ready, flush, rd_hit, mem_valid, mem_ready, empty;
  logic [31:0]  wr_addr, wr_data, rd_addr, mem_addr;
  logic [3:0]   wr_be;
  logic [127:0] mem_data;
  logic [15:0]  mem_be;
  int           n_chk = 0;
  int           n_err = 0;

  typedef struct {
    logic [27:0]  tag;
    logic [127:0] data;
    logic [15:0]  mask;
    bit           open;
    int           idle;
  } line_t;
  line_t q[$];

  cache_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .WORD_WIDTH(32),
                       .LINE_WORDS(4), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be), .flush_i(flush),
    .rd_addr_i(rd_addr), .rd_hit_o(rd_hit), .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_be_o(mem_be), .empty_o(empty));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input logic [31:0] a, input logic f);
    if (f) return 1'b0;
    if (q.size() < DEPTH) return 1'b1;
    foreach (q[i]) if (q[i].open && q[i].tag == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && !q[0].open;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    foreach (q[i]) if (q[i].tag == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic line_t put_word(input line_t l, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] be);
    line_t r;
    int    w;
    r = l;
    w = int'(a[3:2]);
    for (int b = 0; b < 4; b++)
      if (be[b]) begin
        r.data[(w*4 + b)*8 +: 8] = d[b*8 +: 8];
        r.mask[w*4 + b] = 1'b1;
      end
    return r;
  endfunction

  task automatic compare_outputs();
    chk("wr_ready", wr_ready, m_ready(wr_addr, flush));
    chk("mem_valid", mem_valid, m_valid());
    if (m_valid()) begin
      chk("mem_addr", mem_addr, {q[0].tag, 4'h0});
      chk("mem_data", mem_data, q[0].data);
      chk("mem_be", mem_be, q[0].mask);
    end
    chk("rd_hit", rd_hit, m_hit(rd_addr));
    chk("empty", empty, q.size() == 0);
  endtask

  // One clock edge of the reference: drain, age/close, merge or allocate.
  task automatic model_edge(input logic wv, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic f, input logic mr);
    bit    hs, acc;
    int    hit;
    line_t t;
    hs  = m_valid() && mr;
    acc = wv && m_ready(a, f);
    hit = -1;
    if (acc) foreach (q[i]) if (q[i].open && q[i].tag == a[31:4]) hit = i;
    foreach (q[i]) if (q[i].open && i != hit) begin
      t = q[i];
      if (f) t.open = 1'b0;
      else begin
        t.idle++;
        if (t.idle == TO - 1) t.open = 1'b0;
      end
      q[i] = t;
    end
    if (hit >= 0) begin
      t = put_word(q[hit], a, d, be);
      t.idle = 0;
      if (&t.mask) t.open = 1'b0;
      q[hit] = t;
    end
    if (hs) void'(q.pop_front());
    if (acc && hit < 0) begin
      t.tag = a[31:4]; t.data = '0; t.mask = '0; t.idle = 0;
      t = put_word(t, a, d, be);
      t.open = !(&t.mask);
      q.push_back(t);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic f, input logic mr,
                       input logic [31:0] ra);
    @(negedge clk);
    wr_valid = wv; wr_addr = a; wr_data = d; wr_be = be;
    flush = f; mem_ready = mr; rd_addr = ra;
    #1;
    compare_outputs();
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge(wr_valid, wr_addr, wr_data, wr_be, flush, mem_ready);
  endtask

  task automatic step(input logic wv, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic f, input logic mr);
    drive(wv, a, d, be, f, mr, 32'h0);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0; flush = 0; mem_ready = 0; rd_addr = 0;
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_hit", rd_hit, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 16'h0);
    chk("rst_mem_data", mem_data, 128'h0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Four word writes fill a line; it is offered on the next cycle.
    for (int k = 0; k < 4; k++) step(1, 32'h1000 + 4*k, 32'hA0 + k, 4'hF, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("line4_valid", mem_valid, 1'b1);
    chk("line4_addr", mem_addr, 32'h1000);
    chk("line4_data", mem_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("line4_be", mem_be, 16'hFFFF);
    commit();
    step(0, 0, 0, 0, 0, 1);

    // Timeout closure, without and with a deferring merge.
    step(1, 32'h2000, 32'h1234_5678, 4'h3, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (k == 15) chk("to_not_yet", mem_valid, 1'b0);
      if (k == 16) begin
        chk("to_valid", mem_valid, 1'b1);
        chk("to_be", mem_be, 16'h0003);
      end
      commit();
    end
    step(0, 0, 0, 0, 0, 1);
    step(1, 32'h2000, 32'h0000_00AA, 4'h3, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      if (k == 10) drive(1, 32'h2004, 32'h55, 4'h1, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      if (k == 25) chk("merge_to_not_yet", mem_valid, 1'b0);
      if (k == 26) begin
        chk("merge_to_valid", mem_valid, 1'b1);
        chk("merge_to_be", mem_be, 16'h0013);
      end
      commit();
    end
    step(0, 0, 0, 0, 0, 1);

    // Nine distinct lines into eight entries; ninth waits for the first drain.
    for (int k = 0; k < 8; k++) step(1, 32'h5000 + 16*k, 32'h100 + k, 4'hF, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    drive(1, 32'h5080, 32'h108, 4'hF, 0, 0, 0);
    chk("full_ready", wr_ready, 1'b0);
    commit();
    drive(1, 32'h5080, 32'h108, 4'hF, 0, 1, 0);
    chk("full_hs_ready", wr_ready, 1'b0);
    chk("full_hs_addr", mem_addr, 32'h5000);
    commit();
    drive(1, 32'h5080, 32'h108, 4'hF, 0, 1, 0);
    chk("full_after_ready", wr_ready, 1'b1);
    commit();
    for (int k = 0; k < 30; k++) step(0, 0, 0, 0, 0, 1);

    // Flush splits one line into two ordered requests; hazard check on PEND.
    step(1, 32'h3000, 32'h0D0C0B0A, 4'hF, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 32'h300C);
    chk("rd_hit_pend", rd_hit, 1'b1);
    commit();
    drive(0, 0, 0, 0, 0, 0, 32'h3010);
    chk("rd_miss", rd_hit, 1'b0);
    commit();
    step(1, 32'h3004, 32'h1A1B1C1D, 4'hF, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    chk("flush_first_be", mem_be, 16'h000F);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("flush_second_addr", mem_addr, 32'h3000);
    chk("flush_second_be", mem_be, 16'h00F0);
    commit();
    step(0, 0, 0, 0, 0, 1);

    // Reset while a line is being offered.
    for (int k = 0; k < 4; k++) step(1, 32'h4000 + 4*k, 32'hC0 + k, 4'hF, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", mem_valid, 1'b1);
    commit();
    do_reset();

    // Random traffic over a small line pool to provoke merges and fullness.
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a;
      logic [3:0]  be;
      a  = 32'h8000 + 32'($urandom_range(0, 11)) * 16 + 32'($urandom_range(0, 3)) * 4;
      be = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      drive($urandom_range(0, 9) < 7, a, $urandom, be, $urandom_range(0, 31) == 0,
            $urandom_range(0, 9) < 5,
            32'h8000 + 32'($urandom_range(0, 13)) * 16 + 32'($urandom_range(0, 15)));
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
